// File: rtl/bcd_gray_pkg.sv
// Shared types, field constants and helper functions for the BCD-to-Gray
// stepper. Holds the FSM state enum, the BCD byte field positions and the
// two helpers used by the converter and the top level.
package bcd_gray_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      STEP = 2'd2
   } state_t;

   // Display byte layout: {3'b000, tens, units[3:0]}
   localparam int TENS_BIT  = 4;
   localparam int UNITS_MSB = 3;
   localparam int MAX_VAL   = 15;

   function automatic logic [3:0] bin2gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   // A byte is a legal request only if the unused upper bits are clear, the
   // units digit is a decimal digit, and the combined value fits in 0..MAX_VAL.
   function automatic logic bcd_valid(input logic [7:0] v);
      logic [3:0] units;
      logic       tens;
      units = v[UNITS_MSB:0];
      tens  = v[TENS_BIT];
      return (v[7:5] == 3'b000) && (units <= 4'd9) && !(tens && (units > 4'd5));
   endfunction

endpackage

// File: rtl/bcd_gray_stepper_bcd_to_bin.sv
// bcd_to_bin: combinational validation and BCD-to-binary conversion of a
// display-format byte.
//   bcd_i   [7:0] request byte {3'b000, tens, units[3:0]}
//   tgt_o   [3:0] binary value tens*10 + units (meaningful only when valid_o)
//   valid_o       byte is a legal request in the range 0..15
module bcd_to_bin
   import bcd_gray_pkg::*;
(
   input  logic [7:0] bcd_i,
   output logic [3:0] tgt_o,
   output logic       valid_o
);

   logic [3:0] units;
   logic       tens;

   assign units   = bcd_i[UNITS_MSB:0];
   assign tens    = bcd_i[TENS_BIT];
   assign valid_o = bcd_valid(bcd_i);
   // For invalid bytes the sum may wrap; it is never used in that case.
   assign tgt_o   = units + (tens ? 4'd10 : 4'd0);

endmodule

// File: rtl/bcd_gray_stepper.sv
// bcd_gray_stepper: walks a registered 4-bit Gray output from its current code
// to a requested BCD target, one single-bit step every STEP_DIV clocks, along
// the shorter way round the 16-entry Gray ring.
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request strobe
//   in_ready   high while idle (combinational ~busy)
//   bcd_in     request byte {3'b000, tens, units[3:0]}
//   g          registered current Gray code
//   busy       walk in progress
//   done       one-cycle pulse when the target is reached
//   err        one-cycle pulse when a request is rejected
//   dbg_state  current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// in_ready is low for the whole walk, so in_valid is simply ignored then.
module bcd_gray_stepper
   import bcd_gray_pkg::*;
#(
   parameter int unsigned STEP_DIV = 4   // clocks per Gray step, 1..255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] bcd_in,
   output logic [3:0] g,
   output logic       busy,
   output logic       done,
   output logic       err,
   output state_t     dbg_state
);

   localparam logic [7:0] DIV_LOAD  = 8'(STEP_DIV - 1);
   localparam logic       ONE_CYCLE = (STEP_DIV == 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] pos_q, pos_d;
   logic [3:0] tgt_q, tgt_d;
   logic [3:0] g_q, g_d;
   logic       up_q, up_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic [3:0] req_tgt;
   logic       req_valid;
   logic [3:0] dist_up, dist_dn;
   logic       accept;

   bcd_to_bin u_bcd_to_bin (
      .bcd_i   (bcd_in),
      .tgt_o   (req_tgt),
      .valid_o (req_valid)
   );

   assign accept  = in_valid && !busy_q;
   // Modulo-16 distances fall out of 4-bit wraparound subtraction.
   assign dist_up = req_tgt - pos_q;
   assign dist_dn = pos_q - req_tgt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      g_d     = g_q;
      up_d    = up_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!req_valid) begin
                  err_d = 1'b1;
               end else if (req_tgt == pos_q) begin
                  done_d = 1'b1;
               end else begin
                  tgt_d  = req_tgt;
                  up_d   = (dist_up <= dist_dn);   // tie at 8 goes up
                  busy_d = 1'b1;
                  // WAIT covers D-1 cycles and STEP the last one, so each
                  // step lands exactly D edges after the previous one.
                  if (ONE_CYCLE) begin
                     state_d = STEP;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = DIV_LOAD;
                  end
               end
            end
         end

         WAIT: begin
            if (cnt_q <= 8'd1) begin
               state_d = STEP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         STEP: begin
            pos_d = up_q ? (pos_q + 4'd1) : (pos_q - 4'd1);
            g_d   = bin2gray(pos_d);
            if (pos_d == tgt_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (ONE_CYCLE) begin
               state_d = STEP;
            end else begin
               state_d = WAIT;
               cnt_d   = DIV_LOAD;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         pos_q   <= 4'd0;
         tgt_q   <= 4'd0;
         g_q     <= 4'd0;
         up_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         g_q     <= g_d;
         up_q    <= up_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign g         = g_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign in_ready  = !busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_gray_stepper.sv
// Self-checking bench for bcd_gray_stepper with STEP_DIV=4: directed scenarios
// followed by randomized requests, all checked against a position-level model.
module tb_bcd_gray_stepper;
   import bcd_gray_pkg::*;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] bcd_in;
   logic [3:0] g;
   logic       busy;
   logic       done;
   logic       err;
   state_t     dbg_state;

   int vectors    = 0;
   int miscompares = 0;
   int m_pos      = 0;            // model binary position on the ring
   logic [3:0] exp_q[$];          // expected Gray codes of the current walk

   bcd_gray_stepper #(.STEP_DIV(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .g         (g),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [3:0] gray_of(input int p);
      int q;
      q = p % 16;
      return 4'(q ^ (q >> 1));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      m_pos = 0;
      tick();
   endtask

   // Present a request; returns #1 after the edge where it was sampled (E0).
   task automatic issue(input logic [7:0] b, input logic keep);
      in_valid = 1'b1;
      bcd_in   = b;
      tick();
      if (!keep) in_valid = 1'b0;
   endtask

   // Check everything from just after E0 until one edge past completion.
   task automatic expect_result(input logic [7:0] b);
      int tens, units, tgt, up, dn, dir, k;
      logic ok;
      logic [3:0] g0, exp_g;
      tens  = int'(b[4]);
      units = int'(b[3:0]);
      ok    = (b[7:5] == 3'b000) && (units <= 9) && !(tens == 1 && units > 5);
      g0    = gray_of(m_pos);
      if (!ok) begin
         check("err_pulse", err, 1);
         check("err_no_done", done, 0);
         check("err_busy", busy, 0);
         check("err_g", g, g0);
         tick();
         check("err_clear", err, 0);
         check("err_g_after", g, g0);
      end else begin
         tgt = tens * 10 + units;
         if (tgt == m_pos) begin
            check("zero_done", done, 1);
            check("zero_err", err, 0);
            check("zero_busy", busy, 0);
            check("zero_g", g, g0);
            tick();
            check("zero_done_clear", done, 0);
            check("zero_busy_after", busy, 0);
         end else begin
            up  = (tgt - m_pos + 16) % 16;
            dn  = (m_pos - tgt + 16) % 16;
            dir = (up <= dn) ? 1 : -1;
            k   = (dir > 0) ? up : dn;
            exp_q.delete();
            for (int i = 1; i <= k; i++) exp_q.push_back(gray_of(m_pos + dir * i + 16));
            check("walk_busy_rise", busy, 1);
            check("walk_ready_low", in_ready, 0);
            check("walk_g_start", g, g0);
            check("walk_done_low", done, 0);
            exp_g = g0;
            for (int c = 1; c <= D * k; c++) begin
               tick();
               if (c % D == 0) exp_g = exp_q.pop_front();
               check("walk_g", g, exp_g);
               check("walk_err", err, 0);
               if (c == D * k) begin
                  check("walk_done", done, 1);
                  check("walk_busy_fall", busy, 0);
                  check("walk_ready_back", in_ready, 1);
               end else begin
                  check("walk_done_early", done, 0);
                  check("walk_busy_hold", busy, 1);
               end
            end
            m_pos = tgt;
            tick();
            check("walk_done_clear", done, 0);
         end
      end
   endtask

   // ---------------- single-bit-change checker ----------------
   logic [3:0] g_prev;
   logic       rst_seen = 1'b0;
   always @(posedge rst) rst_seen = 1'b1;

   always @(negedge clk) begin
      if (rst || rst_seen || $isunknown(g_prev)) begin
         rst_seen = 1'b0;
      end else begin
         check("gray_one_bit", 32'($countones(g ^ g_prev) <= 1), 1);
         check("done_err_excl", 32'(done && err), 0);
      end
      g_prev = g;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      int v;
      rst      = 1'b1;
      in_valid = 1'b0;
      bcd_in   = 8'h00;
      #3;
      check("rst_g", g, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready", in_ready, 1);
      rst = 1'b0;
      tick();

      // target 13: three steps down 1000, 1001, 1011
      issue(8'h13, 1'b0);
      expect_result(8'h13);
      check("t13_final_g", g, 4'b1011);

      // tie from 0 to 8 goes up, eight steps
      do_reset();
      issue(8'h08, 1'b0);
      expect_result(8'h08);
      check("tie_final_g", g, 4'b1100);

      // zero distance
      issue(8'h08, 1'b0);
      expect_result(8'h08);

      // rejected requests
      issue(8'h0A, 1'b0); expect_result(8'h0A);
      issue(8'h16, 1'b0); expect_result(8'h16);
      issue(8'h20, 1'b0); expect_result(8'h20);
      issue(8'h33, 1'b0); expect_result(8'h33);

      // back-to-back: valid stays high with a different byte during the walk;
      // it must be ignored until one edge after done, then accepted.
      issue(8'h05, 1'b1);
      bcd_in = 8'h12;
      expect_result(8'h05);
      in_valid = 1'b0;
      expect_result(8'h12);

      // reset in the middle of a walk
      issue(8'h03, 1'b0);
      repeat (6) tick();
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_g", g, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", in_ready, 1);
      rst = 1'b0;
      m_pos = 0;
      tick();
      issue(8'h03, 1'b0);
      expect_result(8'h03);

      // randomized requests
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = 8'($urandom_range(0, 255));
         end else begin
            v = $urandom_range(0, 15);
            b = (v >= 10) ? (8'h10 | 8'(v - 10)) : 8'(v);
         end
         issue(b, 1'b0);
         expect_result(b);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
